// File: rtl/uart_event_link_if.sv
// Byte-wide handshake between the event link and the UART core FIFOs.
// The master side (the event link) writes the tx FIFO and pops the show-ahead rx FIFO.
interface uart_event_link_if;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       rx_empty;
    logic       rd_uart;
    logic [7:0] r_data;

    modport master (
        input  tx_full,
        input  rx_empty,
        input  r_data,
        output wr_uart,
        output w_data,
        output rd_uart
    );

    modport slave (
        output tx_full,
        output rx_empty,
        output r_data,
        input  wr_uart,
        input  w_data,
        input  rd_uart
    );
endinterface

// File: rtl/uart_event_link.sv
// Game-event message link: event edges/repeats -> code bytes to the UART tx FIFO, rx bytes -> remote_event pulses.
// Optional framing (0x02, code, ~code) on both paths is enabled by defining UART_EVENT_FRAME_EN.
module uart_event_link #(
    parameter int                N_CH          = 2,
    parameter logic [8*N_CH-1:0] CODES         = {8'h4C, 8'h52},
    parameter logic [N_CH-1:0]   REPEAT_MASK   = 2'b01,
    parameter int                REPEAT_CYCLES = 65_000_000,
    parameter int                CNT_W         = 27
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     i_event_in,
    uart_event_link_if.master   fifo,
    output logic [N_CH-1:0]     o_remote_event,
    output logic [7:0]          o_last_rx,
    output logic [N_CH-1:0]     o_pending,
    output logic [7:0]          o_drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);

`ifdef UART_EVENT_FRAME_EN
    typedef enum logic [1:0] {S_IDLE, S_SOF, S_CODE, S_CHK} tx_state_t;
    typedef enum logic [1:0] {R_WAIT_SOF, R_GOT_SOF, R_GOT_CODE} rx_state_t;
`else
    typedef enum logic {S_IDLE, S_SEND} tx_state_t;
`endif

    logic [N_CH-1:0]  r_ev_q;
    logic [CNT_W-1:0] r_cnt [N_CH];
    logic [N_CH-1:0]  r_pending;
    logic [7:0]       r_drop_cnt;
    logic [7:0]       r_cur_code;
    tx_state_t        r_tx_state;
    logic [7:0]       r_last_rx;
    logic [N_CH-1:0]  r_remote_event;
`ifdef UART_EVENT_FRAME_EN
    rx_state_t        r_rx_state;
    logic [7:0]       r_rx_code;
`endif

    logic [N_CH-1:0]  w_rise;
    logic [N_CH-1:0]  w_req;
    logic [N_CH-1:0]  w_grant;
    logic [7:0]       w_grant_code;
    logic             w_found;
    logic [N_CH-1:0]  w_drop;
    logic [3:0]       w_drop_num;
    logic [8:0]       w_drop_sum;
    logic             w_wr;
    logic [7:0]       w_wdata;
    logic             w_rd;

    // Every channel whose code equals the byte; duplicate codes pulse together.
    function automatic logic [N_CH-1:0] codeMatch(input logic [7:0] b);
        logic [N_CH-1:0] m;
        m = '0;
        for (int i = 0; i < N_CH; i++) begin
            m[i] = (CODES[8*i +: 8] == b);
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ev_q <= '0;
        end else begin
            r_ev_q <= i_event_in;
        end
    end

    always_comb begin
        w_rise = i_event_in & ~r_ev_q;
        w_req  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (REPEAT_MASK[i]) begin
                w_req[i] = w_rise[i] | (i_event_in[i] & (r_cnt[i] == CNT_LAST));
            end else begin
                w_req[i] = w_rise[i];
            end
        end
    end

    // Repeat counters restart on the rising edge so the next repeat lands exactly REPEAT_CYCLES later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!REPEAT_MASK[i] || !i_event_in[i] || w_rise[i] || r_cnt[i] == CNT_LAST) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_grant      = '0;
        w_grant_code = '0;
        w_found      = 1'b0;
        if (r_tx_state == S_IDLE) begin
            for (int i = 0; i < N_CH; i++) begin
                if (r_pending[i] && !w_found) begin
                    w_grant[i]   = 1'b1;
                    w_grant_code = CODES[8*i +: 8];
                    w_found      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_drop     = w_req & r_pending & ~w_grant;
        w_drop_num = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_drop_num = w_drop_num + 4'(w_drop[i]);
        end
        w_drop_sum = {1'b0, r_drop_cnt} + 9'(w_drop_num);
    end

    // A new request beats a same-cycle grant, so the channel stays queued for another send.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_pending  <= (r_pending & ~w_grant) | w_req;
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign w_wr = (r_tx_state != S_IDLE) && !fifo.tx_full && !rst;

`ifdef UART_EVENT_FRAME_EN
    always_comb begin
        w_wdata = '0;
        case (r_tx_state)
            S_SOF:   w_wdata = 8'h02;
            S_CODE:  w_wdata = r_cur_code;
            S_CHK:   w_wdata = ~r_cur_code;
            default: w_wdata = '0;
        endcase
    end
`else
    assign w_wdata = r_cur_code;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= S_IDLE;
            r_cur_code <= '0;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    if (|r_pending) begin
                        r_cur_code <= w_grant_code;
`ifdef UART_EVENT_FRAME_EN
                        r_tx_state <= S_SOF;
`else
                        r_tx_state <= S_SEND;
`endif
                    end
                end
`ifdef UART_EVENT_FRAME_EN
                S_SOF:   if (w_wr) r_tx_state <= S_CODE;
                S_CODE:  if (w_wr) r_tx_state <= S_CHK;
                S_CHK:   if (w_wr) r_tx_state <= S_IDLE;
`else
                S_SEND:  if (w_wr) r_tx_state <= S_IDLE;
`endif
                default: r_tx_state <= S_IDLE;
            endcase
        end
    end

    assign w_rd = !fifo.rx_empty && !rst;

`ifdef UART_EVENT_FRAME_EN
    // Any byte breaking the 0x02, code, ~code pattern discards the frame and resyncs on the next 0x02.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_rx      <= '0;
            r_remote_event <= '0;
            r_rx_state     <= R_WAIT_SOF;
            r_rx_code      <= '0;
        end else begin
            r_remote_event <= '0;
            if (w_rd) begin
                r_last_rx <= fifo.r_data;
                case (r_rx_state)
                    R_WAIT_SOF: begin
                        if (fifo.r_data == 8'h02) begin
                            r_rx_state <= R_GOT_SOF;
                        end
                    end
                    R_GOT_SOF: begin
                        r_rx_code  <= fifo.r_data;
                        r_rx_state <= R_GOT_CODE;
                    end
                    R_GOT_CODE: begin
                        if (fifo.r_data == ~r_rx_code) begin
                            r_remote_event <= codeMatch(r_rx_code);
                        end
                        r_rx_state <= R_WAIT_SOF;
                    end
                    default: r_rx_state <= R_WAIT_SOF;
                endcase
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_rx      <= '0;
            r_remote_event <= '0;
        end else begin
            r_remote_event <= w_rd ? codeMatch(fifo.r_data) : '0;
            if (w_rd) begin
                r_last_rx <= fifo.r_data;
            end
        end
    end
`endif

    assign fifo.wr_uart   = w_wr;
    assign fifo.w_data    = w_wdata;
    assign fifo.rd_uart   = w_rd;
    assign o_remote_event = r_remote_event;
    assign o_last_rx      = r_last_rx;
    assign o_pending      = r_pending;
    assign o_drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_uart_event_link.sv
// Directed self-checking bench for uart_event_link (bare-byte build, REPEAT_CYCLES shortened to 10).
module tb_uart_event_link;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] eventIn = 2'b00;
    logic [1:0] remoteEvent;
    logic [7:0] lastRx;
    logic [1:0] pending;
    logic [7:0] dropCnt;

    uart_event_link_if fifoIf();

    uart_event_link #(
        .N_CH          (2),
        .CODES         ({8'h4C, 8'h52}),
        .REPEAT_MASK   (2'b01),
        .REPEAT_CYCLES (10),
        .CNT_W         (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_event_in     (eventIn),
        .fifo           (fifoIf),
        .o_remote_event (remoteEvent),
        .o_last_rx      (lastRx),
        .o_pending      (pending),
        .o_drop_cnt     (dropCnt)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    // Log every tx FIFO write, sampled mid-cycle just before the edge that commits it.
    logic [7:0] wrData[$];
    int         wrCycle[$];
    always @(negedge clk) begin
        if (fifoIf.wr_uart === 1'b1) begin
            wrData.push_back(fifoIf.w_data);
            wrCycle.push_back(cycle);
        end
    end

    int testsRun = 0;
    int testsFailed = 0;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] ev, input int cycles);
        eventIn = ev;
        waitCycles(cycles);
    endtask

    task automatic clearLog();
        wrData.delete();
        wrCycle.delete();
    endtask

    function automatic int getData(input int k);
        return (wrData.size() > k) ? int'(wrData[k]) : -1;
    endfunction

    function automatic int getCycle(input int k);
        return (wrCycle.size() > k) ? wrCycle[k] : -1000;
    endfunction

    initial begin
        fifoIf.tx_full  = 1'b0;
        fifoIf.rx_empty = 1'b1;
        fifoIf.r_data   = 8'h00;

        waitCycles(3);
        checkOutput("wr_during_reset", int'(fifoIf.wr_uart), 0);
        rst = 1'b0;
        waitCycles(1);
        checkOutput("reset_pending", int'(pending), 0);
        checkOutput("reset_drop", int'(dropCnt), 0);
        checkOutput("reset_last_rx", int'(lastRx), 0);
        checkOutput("reset_remote", int'(remoteEvent), 0);
        checkOutput("reset_rd", int'(fifoIf.rd_uart), 0);

        // One-shot channel 1 held for 5 cycles sends exactly one 'L'.
        clearLog();
        applyStimulus(2'b10, 5);
        applyStimulus(2'b00, 6);
        checkOutput("oneshot_count", wrData.size(), 1);
        checkOutput("oneshot_data", getData(0), 8'h4C);
        checkOutput("oneshot_pending", int'(pending), 0);
        checkOutput("oneshot_drop", int'(dropCnt), 0);

        // Repeating channel 0 held 30 cycles: writes at edge, +10, +20.
        clearLog();
        applyStimulus(2'b01, 30);
        applyStimulus(2'b00, 40);
        checkOutput("repeat_count", wrData.size(), 3);
        checkOutput("repeat_data0", getData(0), 8'h52);
        checkOutput("repeat_data1", getData(1), 8'h52);
        checkOutput("repeat_data2", getData(2), 8'h52);
        checkOutput("repeat_gap01", getCycle(1) - getCycle(0), 10);
        checkOutput("repeat_gap12", getCycle(2) - getCycle(1), 10);
        checkOutput("repeat_pending", int'(pending), 0);

        // Simultaneous requests: lowest index first, 2-cycle spacing.
        clearLog();
        applyStimulus(2'b11, 1);
        applyStimulus(2'b00, 8);
        checkOutput("prio_count", wrData.size(), 2);
        checkOutput("prio_first", getData(0), 8'h52);
        checkOutput("prio_second", getData(1), 8'h4C);
        checkOutput("prio_gap", getCycle(1) - getCycle(0), 2);

        // Backpressure: ch0 stuck in SEND, ch1 pending, repeated ch1 request is dropped.
        clearLog();
        fifoIf.tx_full = 1'b1;
        applyStimulus(2'b01, 1);
        applyStimulus(2'b00, 2);
        applyStimulus(2'b10, 1);
        applyStimulus(2'b00, 2);
        checkOutput("bp_pending_before", int'(pending), 2'b10);
        checkOutput("bp_drop_before", int'(dropCnt), 0);
        applyStimulus(2'b10, 1);
        applyStimulus(2'b00, 20);
        checkOutput("bp_no_writes", wrData.size(), 0);
        checkOutput("bp_drop", int'(dropCnt), 1);
        checkOutput("bp_pending_held", int'(pending), 2'b10);
        fifoIf.tx_full = 1'b0;
        waitCycles(8);
        checkOutput("bp_release_count", wrData.size(), 2);
        checkOutput("bp_release_first", getData(0), 8'h52);
        checkOutput("bp_release_second", getData(1), 8'h4C);
        checkOutput("bp_release_pending", int'(pending), 0);

        // Rx: 'L', 'A', 'R' back-to-back decode to 10, 00, 01.
        fifoIf.rx_empty = 1'b0;
        fifoIf.r_data   = 8'h4C;
        #1;
        checkOutput("rx_rd_active", int'(fifoIf.rd_uart), 1);
        waitCycles(1);
        checkOutput("rx_ev_L", int'(remoteEvent), 2'b10);
        checkOutput("rx_last_L", int'(lastRx), 8'h4C);
        fifoIf.r_data = 8'h41;
        waitCycles(1);
        checkOutput("rx_ev_A", int'(remoteEvent), 2'b00);
        checkOutput("rx_last_A", int'(lastRx), 8'h41);
        fifoIf.r_data = 8'h52;
        waitCycles(1);
        checkOutput("rx_ev_R", int'(remoteEvent), 2'b01);
        checkOutput("rx_last_R", int'(lastRx), 8'h52);
        fifoIf.rx_empty = 1'b1;
        waitCycles(1);
        checkOutput("rx_ev_idle", int'(remoteEvent), 2'b00);
        checkOutput("rx_rd_idle", int'(fifoIf.rd_uart), 0);

        // Reset while stuck in SEND abandons the byte.
        clearLog();
        fifoIf.tx_full = 1'b1;
        applyStimulus(2'b10, 1);
        applyStimulus(2'b00, 3);
        checkOutput("rst_stuck_no_write", wrData.size(), 0);
        rst = 1'b1;
        fifoIf.tx_full = 1'b0;
        #1;
        checkOutput("rst_wr_gated", int'(fifoIf.wr_uart), 0);
        waitCycles(1);
        rst = 1'b0;
        #1;
        checkOutput("rst_after_wr", int'(fifoIf.wr_uart), 0);
        checkOutput("rst_after_pending", int'(pending), 0);
        checkOutput("rst_after_drop", int'(dropCnt), 0);
        checkOutput("rst_after_last_rx", int'(lastRx), 0);
        checkOutput("rst_after_remote", int'(remoteEvent), 0);
        waitCycles(10);
        checkOutput("rst_no_late_write", wrData.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/uart_event_link.md
Name: uart_event_link

Overview:
- Parametrised game-event message link between game logic and the UART core (tx FIFO write port, rx FIFO read port).
- Maps N_CH event inputs to per-channel code bytes and queues them as pending requests.
- Channels are one-shot (rising edge) or repeating (periodic while held).
- A fixed-priority arbiter writes codes into the UART tx FIFO under tx_full backpressure; received bytes are decoded back into per-channel remote_event pulses.

Parameters:
- N_CH, 2, number of event channels (1..8).
- CODES, {8'h4C,8'h52}, packed code bytes; channel i uses CODES[8*i+7:8*i] (ch0=0x52 'R', ch1=0x4C 'L').
- REPEAT_MASK, 2'b01, bit i=1 makes channel i repeating; 0 makes it one-shot.
- REPEAT_CYCLES, 65_000_000, repeat period in clk cycles (must be >= 2).
- CNT_W, 27, width of each repeat counter; must hold REPEAT_CYCLES-1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- event_in  in  N_CH  level event requests, synchronous to clk
- tx_full  in  1  UART tx FIFO full
- wr_uart  out  1  tx FIFO write strobe
- w_data  out  8  tx FIFO write data
- rx_empty  in  1  UART rx FIFO empty
- r_data  in  8  rx FIFO head byte (show-ahead, valid while rx_empty=0)
- rd_uart  out  1  rx FIFO read/pop strobe
- remote_event  out  N_CH  one-cycle pulse per matched received code
- last_rx  out  8  last byte popped from rx FIFO
- pending  out  N_CH  queued, not yet sent requests
- drop_cnt  out  8  saturating count of requests lost to an already-pending channel

Behaviour:
- Reset values: all state 0, pending=0, drop_cnt=0, last_rx=0, remote_event=0, state=IDLE; wr_uart=0 and rd_uart=0 during reset. A frame in progress is abandoned with no further writes.
- event_in is registered once (ev_q) for edge detection; ev_q resets to 0, so an input held high through reset counts as a rising edge on the first cycle after reset.
- One-shot channel: a request fires when event_in[i] & ~ev_q[i].
- Repeating channel:
  - A request fires on the rising edge, then on every REPEAT_CYCLES-th cycle while event_in[i] stays high.
  - cnt[i] clears on the rising edge, increments while high, fires and wraps to 0 at REPEAT_CYCLES-1, and is held at 0 while low.
- Request handling:
  - A request sets pending[i].
  - If pending[i] is already 1 and is not being granted this cycle, drop_cnt increments, saturating at 255.
  - If a request and a grant of the same channel occur in the same cycle, the set wins: pending stays 1 and no drop is counted.
- Tx FSM without FRAME_EN, states IDLE and SEND:
  - IDLE: when pending != 0, grant the lowest index, latch its code into cur_code, clear pending[i] and go to SEND.
  - SEND: wr_uart = ~tx_full (combinational) and w_data = cur_code. When wr_uart=1, go to IDLE.
  - Throughput: at most 1 byte per 2 cycles.
- Rx path:
  - rd_uart = ~rx_empty (combinational); one byte per cycle maximum.
  - When rd_uart=1, last_rx <= r_data. For every i with r_data == code i, remote_event[i] pulses in the next cycle only.
  - Unmatched bytes update only last_rx.
  - Identical codes on multiple channels pulse all matching bits.
- The tx and rx paths are independent and may be active in the same cycle.

Optional Feature:
- Macro: UART_EVENT_FRAME_EN.
- Defined: tx states are IDLE -> SOF -> CODE -> CHK -> IDLE.
  - Bytes written in order: 0x02, cur_code, cur_code ^ 8'hFF.
  - Each state writes only when tx_full=0 and advances on its write.
  - Rx decoding runs a matching FSM (WAIT_SOF, GOT_SOF, GOT_CODE). remote_event pulses only after a valid 0x02, code, ~code sequence.
  - On a bad checksum, or any non-0x02 byte in WAIT_SOF, the frame is discarded and the FSM returns to WAIT_SOF.
  - last_rx still tracks every popped byte.
- Undefined: behaviour is as described in Behaviour (single bare byte per message).

Test Plan:
- Pulse event_in[1] high for 5 cycles with tx_full=0 -> exactly one write, w_data=0x4C; pending returns to 0; drop_cnt=0.
- Hold event_in[0] (repeating) for 3*REPEAT_CYCLES with REPEAT_CYCLES=10 in the bench -> 0x52 written 3 times (rising edge, +10, +20) and never again after release.
- Raise both channels in the same cycle with tx_full=0 -> 0x52 written first, then 0x4C, with a 2-cycle spacing.
- Hold tx_full=1 for 20 cycles while pending[1]=1 and pulse event_in[1] again -> wr_uart stays 0 and drop_cnt=1; after release, one 0x4C is written.
- Feed rx bytes 0x4C, 0x41, 0x52 back-to-back -> remote_event pulses 2'b10, 2'b00, 2'b01 in consecutive cycles; last_rx ends at 0x52.
- Assert rst during SEND with tx_full=1 -> no write follows; all outputs are 0 the cycle after reset; drop_cnt=0.
